// File: rtl/vc_input_buffer.sv
// vc_input_buffer: router input port with NUM_VC virtual-channel FIFOs.
// Upstream writes into the VC selected by phase; the crossbar drains the
// VC selected by the previous phase (prv). Head presentation, ready and
// valid are combinational; counts, pointers and the underflow flag are
// cleared asynchronously while FIFO storage is left untouched.
module vc_input_buffer #(
    parameter  int DATA_W = 64,
    parameter  int NUM_VC = 2,
    parameter  int DEPTH  = 2,
    localparam int VC_W   = $clog2(NUM_VC),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VC_W-1:0]         phase,
    input  logic                    si,
    output logic                    ri,
    input  logic [DATA_W-1:0]       di,
    input  logic                    fwd_en,
    output logic [DATA_W-1:0]       do_data,
    output logic                    fwd_v,
    output logic [NUM_VC*CNT_W-1:0] vc_cnt,
    output logic                    err_udf
);

    // A one-entry FIFO still needs a 1-bit pointer; it simply never moves.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_r    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_r [NUM_VC];
    logic [CNT_W-1:0]  cnt_r    [NUM_VC];
    logic              err_udf_r;

    logic [VC_W-1:0]   prv_s;
    logic              push_s;
    logic              pop_s;

    // Pointer advance with wrap at DEPTH (DEPTH need not fill PTR_W bits).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Previous-phase VC (natural wrap in VC_W bits) and handshake qualifiers.
    always_comb begin
        prv_s  = phase - VC_W'(1);
        ri     = (cnt_r[phase] != CNT_W'(DEPTH));
        fwd_v  = (cnt_r[prv_s] != CNT_W'(0));
        push_s = si && ri;
        pop_s  = fwd_en && fwd_v;
    end

    // Head flit of the drain VC; forced to zero when empty so stale data never leaks.
    always_comb begin
        do_data = '0;
        if (fwd_v) begin
            do_data = mem_r[prv_s][rd_ptr_r[prv_s]];
        end else begin
            do_data = '0;
        end
    end

    // Flatten per-VC occupancy onto the output bus.
    always_comb begin
        vc_cnt = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            vc_cnt[v*CNT_W +: CNT_W] = cnt_r[v];
        end
    end

    assign err_udf = err_udf_r;

    // FIFO storage write; intentionally not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[phase][wr_ptr_r[phase]] <= di;
        end
    end

    // Pointer/count bookkeeping and sticky underflow flag.
    // Push (phase) and pop (prv) never hit the same VC, so each VC sees at most one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_r[v] <= '0;
                rd_ptr_r[v] <= '0;
                cnt_r[v]    <= '0;
            end
            err_udf_r <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_s && (phase == VC_W'(v))) begin
                    wr_ptr_r[v] <= ptr_inc(wr_ptr_r[v]);
                    cnt_r[v]    <= cnt_r[v] + CNT_W'(1);
                end else if (pop_s && (prv_s == VC_W'(v))) begin
                    rd_ptr_r[v] <= ptr_inc(rd_ptr_r[v]);
                    cnt_r[v]    <= cnt_r[v] - CNT_W'(1);
                end else begin
                    wr_ptr_r[v] <= wr_ptr_r[v];
                    rd_ptr_r[v] <= rd_ptr_r[v];
                    cnt_r[v]    <= cnt_r[v];
                end
            end
            if (fwd_en && !fwd_v) begin
                err_udf_r <= 1'b1;
            end else begin
                err_udf_r <= err_udf_r;
            end
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Directed testbench for vc_input_buffer: a 2-VC/2-deep instance and a
// 4-VC/4-deep instance sharing clock and reset, with hand-computed expectations.
module tb_vc_input_buffer;

    logic        clk;
    logic        reset;

    // 2 VC x 2 deep instance (CNT_W = 2, vc_cnt 4 bits)
    logic        ph2;
    logic        si2;
    logic        ri2;
    logic [63:0] di2;
    logic        fe2;
    logic [63:0] do2;
    logic        fv2;
    logic [3:0]  cnt2;
    logic        err2;

    // 4 VC x 4 deep instance (CNT_W = 3, vc_cnt 12 bits)
    logic [1:0]  ph4;
    logic        si4;
    logic        ri4;
    logic [63:0] di4;
    logic        fe4;
    logic [63:0] do4;
    logic        fv4;
    logic [11:0] cnt4;
    logic        err4;

    int checks;
    int failures;

    vc_input_buffer #(.DATA_W(64), .NUM_VC(2), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .phase(ph2), .si(si2), .ri(ri2), .di(di2),
        .fwd_en(fe2), .do_data(do2), .fwd_v(fv2), .vc_cnt(cnt2), .err_udf(err2)
    );

    vc_input_buffer #(.DATA_W(64), .NUM_VC(4), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .phase(ph4), .si(si4), .ri(ri4), .di(di4),
        .fwd_en(fe4), .do_data(do4), .fwd_v(fv4), .vc_cnt(cnt4), .err_udf(err4)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs are changed 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b0;
        ph2 = 1'b0; si2 = 1'b0; di2 = 64'h0; fe2 = 1'b0;
        ph4 = 2'd0; si4 = 1'b0; di4 = 64'h0; fe4 = 1'b0;
        #2;
        check_eq("rst_ri",   {63'h0, ri2},  64'h1);
        check_eq("rst_fwdv", {63'h0, fv2},  64'h0);
        check_eq("rst_do",   do2,           64'h0);
        check_eq("rst_cnt",  {60'h0, cnt2}, 64'h0);
        check_eq("rst_err",  {63'h0, err2}, 64'h0);
        tick();
        reset = 1'b1;
        tick();

        // Basic flow
        ph2 = 1'b0; si2 = 1'b1; di2 = 64'hA5A5_0000_0000_0001;
        #1 check_eq("basic_ri", {63'h0, ri2}, 64'h1);
        tick();
        ph2 = 1'b1; si2 = 1'b0;
        #1;
        check_eq("basic_fwdv", {63'h0, fv2},  64'h1);
        check_eq("basic_do",   do2,           64'hA5A5_0000_0000_0001);
        check_eq("basic_cnt",  {60'h0, cnt2}, 64'h1);
        fe2 = 1'b1;
        tick();
        fe2 = 1'b0;
        #1 check_eq("basic_popcnt", {60'h0, cnt2}, 64'h0);
        ph2 = 1'b0;
        tick();
        ph2 = 1'b1;
        #1;
        check_eq("basic_fwdv0", {63'h0, fv2}, 64'h0);
        check_eq("basic_do0",   do2,          64'h0);
        tick();

        // Fill / full / FIFO order across pointer wrap
        ph2 = 1'b0; si2 = 1'b1; di2 = 64'h11;
        tick();
        ph2 = 1'b1; si2 = 1'b0;
        tick();
        ph2 = 1'b0; si2 = 1'b1; di2 = 64'h22;
        tick();
        ph2 = 1'b1; si2 = 1'b0;
        tick();
        ph2 = 1'b0;
        #1;
        check_eq("full_ri",  {63'h0, ri2},  64'h0);
        check_eq("full_cnt", {60'h0, cnt2}, 64'h2);
        si2 = 1'b1; di2 = 64'h99;
        tick();
        si2 = 1'b0; ph2 = 1'b1;
        #1;
        check_eq("drop_cnt", {60'h0, cnt2}, 64'h2);
        check_eq("pop1_do",  do2,           64'h11);
        fe2 = 1'b1;
        tick();
        fe2 = 1'b0; ph2 = 1'b0;
        tick();
        ph2 = 1'b1;
        #1;
        check_eq("pop2_do",  do2,           64'h22);
        check_eq("pop2_cnt", {60'h0, cnt2}, 64'h1);
        fe2 = 1'b1;
        tick();
        fe2 = 1'b0;
        #1;
        check_eq("drain_cnt",  {60'h0, cnt2}, 64'h0);
        check_eq("drain_fwdv", {63'h0, fv2},  64'h0);

        // Underflow at phase 1 with VC0 empty
        fe2 = 1'b1;
        #1 check_eq("udf_pre", {63'h0, err2}, 64'h0);
        tick();
        fe2 = 1'b0;
        #1;
        check_eq("udf_err", {63'h0, err2}, 64'h1);
        check_eq("udf_cnt", {60'h0, cnt2}, 64'h0);

        // Simultaneous push into VC1 and pop of VC0
        ph2 = 1'b0; si2 = 1'b1; di2 = 64'h44;
        tick();
        ph2 = 1'b1; si2 = 1'b1; di2 = 64'h33; fe2 = 1'b1;
        #1 check_eq("sim_do", do2, 64'h44);
        tick();
        si2 = 1'b0; fe2 = 1'b0;
        #1;
        check_eq("sim_cnt",    {60'h0, cnt2}, 64'h4);
        check_eq("sim_err",    {63'h0, err2}, 64'h1);
        ph2 = 1'b0;
        #1 check_eq("sim_vc1_do", do2, 64'h33);

        // Mid-cycle asynchronous reset with VC0 holding two flits
        si2 = 1'b1; di2 = 64'h55;
        tick();
        ph2 = 1'b1; si2 = 1'b0;
        tick();
        ph2 = 1'b0; si2 = 1'b1; di2 = 64'h66;
        tick();
        si2 = 1'b0;
        #1 check_eq("pre_rst_cnt", {60'h0, cnt2}, 64'h6);
        #1 reset = 1'b0;
        #1;
        check_eq("arst_ri",   {63'h0, ri2},  64'h1);
        check_eq("arst_fwdv", {63'h0, fv2},  64'h0);
        check_eq("arst_do",   do2,           64'h0);
        check_eq("arst_cnt",  {60'h0, cnt2}, 64'h0);
        check_eq("arst_err",  {63'h0, err2}, 64'h0);
        tick();
        reset = 1'b1;
        tick();

        // 4-VC instance: push each cycle, head of prv is previous flit
        for (int p = 0; p < 4; p++) begin
            ph4 = 2'(p); si4 = 1'b1; di4 = 64'h100 + 64'(p);
            #1;
            if (p == 0) begin
                check_eq("v4_fwdv0", {63'h0, fv4}, 64'h0);
            end else begin
                check_eq("v4_do", do4, 64'h100 + 64'(p - 1));
            end
            tick();
        end
        ph4 = 2'd0; di4 = 64'h104;
        #1;
        check_eq("v4_wrap_do",  do4,            64'h103);
        check_eq("v4_wrap_cnt", {52'h0, cnt4},  64'h249);
        tick();
        si4 = 1'b0;
        #1 check_eq("v4_cnt_after", {52'h0, cnt4}, 64'h24A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
- Parametrised router input port: per-port input control plus NUM_VC virtual-channel FIFOs, each DEPTH entries deep.
- Generalises the two-entry even/odd input handler to N channels with real queueing, occupancy reporting and an error flag.
- The router phase counter selects a VC. Upstream writes into the current-phase VC. The crossbar drains the previous-phase VC.

Parameters:
- DATA_W, 64, flit width in bits.
- NUM_VC, 2, number of virtual channels. Power of 2, at least 2.
- DEPTH, 2, entries per VC FIFO. Power of 2, at least 1.
- VC_W, $clog2(NUM_VC), phase index width. Derived; do not override.
- CNT_W, $clog2(DEPTH+1), per-VC occupancy width. Derived.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- phase  in  VC_W  current VC index from the router phase counter. Advances by 1 mod NUM_VC per cycle in normal use; any value is legal.
- si  in  1  upstream send request.
- ri  out  1  ready: VC[phase] has a free entry.
- di  in  DATA_W  upstream flit.
- fwd_en  in  1  crossbar pops the head of VC[prv].
- do  out  DATA_W  head flit of VC[prv].
- fwd_v  out  1  VC[prv] is non-empty.
- vc_cnt  out  NUM_VC*CNT_W  per-VC occupancy. VC i occupies bits [i*CNT_W +: CNT_W].
- err_udf  out  1  sticky underflow flag.

Behaviour:
- Definitions: prv = (phase - 1) mod NUM_VC, computed in VC_W bits with natural wrap. With phase = 0, prv = NUM_VC-1.
- Reset (reset = 0, asynchronous, with no clock needed):
  - all counts and pointers 0, so ri = 1, fwd_v = 0, do = 0, vc_cnt = 0, err_udf = 0.
  - FIFO storage is not cleared.
  - Deassertion takes effect at the first clk edge with reset = 1.
- ri is combinational: ri = (cnt[phase] != DEPTH).
- Push: on a clk edge with si && ri, di is written at wr_ptr[phase]; wr_ptr increments mod DEPTH; cnt[phase] increments. With si && !ri, nothing is written and no flag is raised (legal stall).
- fwd_v = (cnt[prv] != 0).
- do = mem[prv][rd_ptr[prv]] when fwd_v = 1, else all zeros. Both are combinational: zero-latency head presentation, so a flit pushed at edge t is visible on do at edge t+1 at the earliest, once phase has advanced.
- Pop: on a clk edge with fwd_en && fwd_v, rd_ptr[prv] increments mod DEPTH and cnt[prv] decrements.
- Underflow: fwd_en && !fwd_v has no state change except err_udf <= 1. err_udf stays high until reset.
- Push and pop always target different VCs in the same cycle, because phase != prv for NUM_VC >= 2. There are no same-FIFO collisions and no bypass path; each VC counter changes by at most 1 per cycle.
- Full: a push into a full VC is impossible (ri = 0). A full VC whose head is popped while it is prv becomes writable again when it is next the phase VC.
- Empty: do is forced to zero so stale flits never leak to the crossbar.
- Wrap: pointers wrap at DEPTH. With DEPTH = 1, pointers are constant 0 and cnt toggles between 0 and 1, which matches the legacy two-VC behaviour when NUM_VC = 2.
- Reset mid-operation: all queued flits are discarded immediately. Outputs reach their reset values within the same cycle, without waiting for clk.
- All state is held when si = 0 and fwd_en = 0.

Test Plan (DATA_W=64, NUM_VC=2, DEPTH=2 unless noted):
1. Reset check: assert reset = 0 mid-cycle with VC0 holding 2 flits.
   - Required: immediately ri = 1, fwd_v = 0, do = 0, vc_cnt = 0, err_udf = 0.
2. Basic flow: phase toggles 0/1; push 0xA5A5_0000_0000_0001 at phase = 0.
   - Next cycle (phase = 1): fwd_v = 1 and do = that value.
   - With fwd_en = 1 there: vc_cnt VC0 goes to 0 and fwd_v drops to 0 in the following phase = 1 slot.
3. Fill/full: hold fwd_en = 0 and push 0x11 then 0x22 into VC0 on successive phase = 0 cycles.
   - Then ri = 0 at phase = 0 and vc_cnt VC0 = 2.
   - A third si is dropped.
   - Pops then return 0x11 then 0x22 (FIFO order across a pointer wrap).
4. Underflow: at phase = 1 with VC0 empty, assert fwd_en.
   - Required: err_udf = 1 from the next edge, counts unchanged.
   - err_udf stays 1 through later traffic until reset.
5. Simultaneous push and pop: at phase = 1 push 0x33 into VC1 while popping VC0 (count 1).
   - Required: VC1 count = 1 and VC0 count = 0 in the same edge.
6. NUM_VC=4, DEPTH=4: phase sequence 0,1,2,3,0 with a push each cycle.
   - Required: at each phase p, do = the flit pushed at phase p-1.
   - At phase = 0, prv = 3 (wrap), and vc_cnt reports 1 in every VC before any pops.
